// File: rtl/spi_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module     : spi_pkg                                                  |
// | Description: Shared types and constants for the synchronous SPI slave |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
package spi_pkg;

    localparam int DWIDTH        = 8;
    localparam int AWIDTH        = 4;
    localparam int SPI_FRAME_LEN = 1 + AWIDTH + DWIDTH;

    // Bit positions inside driver_cfg
    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } spi_slv_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module     : spi_sync_edge                                            |
// | Description: Multi-flop synchronizer with rise/fall detection         |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;
    logic [SYNC_STAGES:0]   r_fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {SYNC_STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
            r_fill  <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], din};
            r_prev  <= r_chain[SYNC_STAGES-1];
            r_fill  <= {r_fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are reported only once both compared samples are real input samples,
    // so a line already away from its reset level causes no spurious edge.
    assign dout = r_chain[SYNC_STAGES-1];
    assign rise = r_fill[SYNC_STAGES] &  dout & ~r_prev;
    assign fall = r_fill[SYNC_STAGES] & ~dout &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module     : spi_slave_sync                                           |
// | Description: clk-domain SPI slave with register file, all SPI modes.  |
// |              Define SPI_SLV_FRAME_ERR_EN to enable the frame_err pulse|
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
module spi_slave_sync #(
    parameter int DWIDTH      = spi_pkg::DWIDTH,
    parameter int AWIDTH      = spi_pkg::AWIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        driver_cfg,
    input  logic              sck,
    input  logic              mosi,
    input  logic              ss_n,
    output logic              miso,
    output logic              miso_oe,
    output logic              wr_valid,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data,
    input  logic [AWIDTH-1:0] loc_addr,
    output logic [DWIDTH-1:0] loc_rdata,
    output logic              frame_err
);
    import spi_pkg::*;

    localparam int FRAME_LEN = 1 + AWIDTH + DWIDTH;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int DEPTH     = 2 ** AWIDTH;

    logic w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall, w_mosi;
    logic w_unused_sck, w_unused_ss, w_unused_mosi_rise, w_unused_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst(rst), .din(sck),
        .dout(w_unused_sck), .rise(w_sck_rise), .fall(w_sck_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .din(ss_n),
        .dout(w_unused_ss), .rise(w_ss_rise), .fall(w_ss_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(mosi),
        .dout(w_mosi), .rise(w_unused_mosi_rise), .fall(w_unused_mosi_fall)
    );

    spi_slv_state_t    r_state, w_next_state;
    logic              r_cpol, r_cpha;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_rw;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_data;
    logic [DWIDTH-1:0] r_tx;
    logic              r_miso;
    logic              r_wr_valid;
    logic [AWIDTH-1:0] r_wr_addr;
    logic [DWIDTH-1:0] r_wr_data;
    logic [DWIDTH-1:0] r_regs [DEPTH];

    logic              w_lead, w_trail, w_sample, w_shift;
    logic              w_last_addr, w_last_bit, w_abort;
    logic [AWIDTH-1:0] w_addr_next;
    logic [DWIDTH-1:0] w_data_next;

    assign w_lead      = r_cpol ? w_sck_fall : w_sck_rise;
    assign w_trail     = r_cpol ? w_sck_rise : w_sck_fall;
    assign w_sample    = r_cpha ? w_trail : w_lead;
    assign w_shift     = r_cpha ? w_lead : w_trail;
    assign w_last_addr = w_sample && (r_bit_cnt == CNT_W'(AWIDTH));
    assign w_last_bit  = w_sample && (r_bit_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_abort     = ((r_state == CMD) || (r_state == DATA)) && w_ss_rise;
    assign w_addr_next = AWIDTH'({r_addr, w_mosi});
    assign w_data_next = DWIDTH'({r_data, w_mosi});

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_ss_fall)   w_next_state = CMD;
            CMD:     if (w_ss_rise)   w_next_state = IDLE;
                     else if (w_last_addr) w_next_state = DATA;
            DATA:    if (w_ss_rise)   w_next_state = IDLE;
                     else if (w_last_bit)  w_next_state = DONE;
            DONE:    if (w_ss_rise)   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_bit_cnt  <= '0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_tx       <= '0;
            r_miso     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else begin
            r_wr_valid <= 1'b0;
            case (r_state)
                IDLE: if (w_ss_fall) begin
                    r_cpol    <= driver_cfg[CPOL_BIT];
                    r_cpha    <= driver_cfg[CPHA_BIT];
                    r_bit_cnt <= '0;
                    r_rw      <= 1'b0;
                    r_addr    <= '0;
                    r_data    <= '0;
                    r_miso    <= 1'b0;
                end
                CMD: if (!w_ss_rise && w_sample) begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == '0) r_rw   <= w_mosi;
                    else                 r_addr <= w_addr_next;
                    if (w_last_addr && r_rw) r_tx <= r_regs[w_addr_next];
                end
                DATA: if (!w_ss_rise) begin
                    if (w_sample) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (!r_rw) r_data <= w_data_next;
                        if (w_last_bit && !r_rw) begin
                            r_regs[r_addr] <= w_data_next;
                            r_wr_valid     <= 1'b1;
                            r_wr_addr      <= r_addr;
                            r_wr_data      <= w_data_next;
                        end
                    end
                    if (w_shift && r_rw) begin
                        r_miso <= r_tx[DWIDTH-1];
                        r_tx   <= r_tx << 1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign miso      = ((r_state == DATA) && r_rw) ? r_miso : 1'b0;
    assign miso_oe   = (r_state != IDLE);
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign loc_rdata = r_regs[loc_addr];

`ifdef SPI_SLV_FRAME_ERR_EN
    // Over-clocking means another sample edge after the frame completed;
    // the trailing edge of the final CPHA=0 bit is legitimate and not flagged.
    logic r_frame_err;
    always_ff @(posedge clk) begin
        if (rst) r_frame_err <= 1'b0;
        else     r_frame_err <= w_abort || ((r_state == DONE) && w_sample);
    end
    assign frame_err = r_frame_err;
`else
    logic w_unused_abort;
    assign w_unused_abort = w_abort;
    assign frame_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module     : tb_spi_slave_sync                                        |
// | Description: Directed self-checking bench for spi_slave_sync          |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
module tb_spi_slave_sync;

    localparam int HALF = 8;
`ifdef SPI_SLV_FRAME_ERR_EN
    localparam int FE = 1;
`else
    localparam int FE = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] driver_cfg = 2'b00;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       ss_n = 1'b1;
    logic       miso, miso_oe, wr_valid, frame_err;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] loc_addr = 4'd0;
    logic [7:0] loc_rdata;

    int checks = 0;
    int errors = 0;
    int wv_total = 0;
    int fe_total = 0;

    spi_slave_sync dut (
        .clk(clk), .rst(rst), .driver_cfg(driver_cfg), .sck(sck), .mosi(mosi),
        .ss_n(ss_n), .miso(miso), .miso_oe(miso_oe), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .loc_addr(loc_addr),
        .loc_rdata(loc_rdata), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid === 1'b1)  wv_total++;
        if (frame_err === 1'b1) fe_total++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master side of one frame; bits past the 13th are driven as 1.
    task automatic spi_xfer(input logic [1:0] mode, input logic [12:0] frame,
                            input int npulses, output logic [7:0] rd, output int oe_bad);
        logic cpol, cpha, b;
        cpol = mode[1];
        cpha = mode[0];
        rd = 8'h00;
        oe_bad = 0;
        driver_cfg = mode;
        sck = cpol;
        mosi = 1'b0;
        wait_clk(6);
        ss_n = 1'b0;
        if (!cpha) mosi = frame[12];
        wait_clk(HALF);
        for (int i = 0; i < npulses; i++) begin
            if (!cpha) begin
                if (i >= 5 && i < 13) rd = {rd[6:0], miso};
                if (miso_oe !== 1'b1) oe_bad++;
            end
            sck = ~cpol;
            b = (i < 13) ? frame[12-i] : 1'b1;
            if (cpha) mosi = b;
            wait_clk(HALF);
            if (cpha) begin
                if (i >= 5 && i < 13) rd = {rd[6:0], miso};
                if (miso_oe !== 1'b1) oe_bad++;
            end
            sck = cpol;
            b = (i + 1 < 13) ? frame[11-i] : 1'b1;
            if (!cpha) mosi = b;
            wait_clk(HALF);
        end
        ss_n = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        logic [7:0]  rd;
        logic [12:0] fr;
        int oe_bad, wv0, fe0;

        // Reset state
        wait_clk(5);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_loc_rdata", loc_rdata, 0);
        rst = 1'b0;
        wait_clk(6);

        // Mode 0 write A5 -> addr 5
        wv0 = wv_total; fe0 = fe_total;
        spi_xfer(2'b00, {1'b0, 4'h5, 8'hA5}, 13, rd, oe_bad);
        check("m0_wr_valid_cnt", wv_total - wv0, 1);
        check("m0_wr_addr", wr_addr, 4'h5);
        check("m0_wr_data", wr_data, 8'hA5);
        check("m0_oe_during", oe_bad, 0);
        check("m0_frame_err", fe_total - fe0, 0);
        loc_addr = 4'h5;
        wait_clk(1);
        check("m0_loc_rdata", loc_rdata, 8'hA5);
        check("m0_oe_after", miso_oe, 0);

        // Mode 3 read addr 5
        wv0 = wv_total;
        spi_xfer(2'b11, {1'b1, 4'h5, 8'h00}, 13, rd, oe_bad);
        check("m3_rd_data", rd, 8'hA5);
        check("m3_oe_during", oe_bad, 0);
        check("m3_no_wr_valid", wv_total - wv0, 0);
        check("m3_miso_idle", miso, 0);

        // Mode 1 write 3C -> F, mode 2 read back
        wv0 = wv_total;
        spi_xfer(2'b01, {1'b0, 4'hF, 8'h3C}, 13, rd, oe_bad);
        check("m1_wr_valid_cnt", wv_total - wv0, 1);
        check("m1_wr_addr", wr_addr, 4'hF);
        check("m1_wr_data", wr_data, 8'h3C);
        spi_xfer(2'b10, {1'b1, 4'hF, 8'h00}, 13, rd, oe_bad);
        check("m2_rd_data", rd, 8'h3C);
        check("m2_oe_during", oe_bad, 0);
        loc_addr = 4'hF;
        wait_clk(1);
        check("m2_loc_rdata", loc_rdata, 8'h3C);

        // Abort after 10 of 13 bits
        wv0 = wv_total; fe0 = fe_total;
        spi_xfer(2'b00, {1'b0, 4'h2, 8'hFF}, 10, rd, oe_bad);
        check("abort_no_wr_valid", wv_total - wv0, 0);
        check("abort_frame_err", fe_total - fe0, FE);
        check("abort_wr_addr_held", wr_addr, 4'hF);
        check("abort_wr_data_held", wr_data, 8'h3C);
        check("abort_oe", miso_oe, 0);
        loc_addr = 4'h2;
        wait_clk(1);
        check("abort_reg2", loc_rdata, 8'h00);

        // Reset in the middle of a mode 0 read
        wv0 = wv_total;
        fr = {1'b1, 4'h5, 8'h00};
        driver_cfg = 2'b00;
        sck = 1'b0;
        wait_clk(6);
        ss_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mosi = fr[12-i];
            wait_clk(HALF);
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
        check("midrd_oe_before_rst", miso_oe, 1);
        rst = 1'b1;
        wait_clk(3);
        check("midrd_rst_oe", miso_oe, 0);
        check("midrd_rst_miso", miso, 0);
        check("midrd_rst_wr_addr", wr_addr, 0);
        check("midrd_rst_wr_data", wr_data, 0);
        check("midrd_rst_wr_valid", wr_valid, 0);
        loc_addr = 4'h5;
        wait_clk(1);
        check("midrd_rst_reg5", loc_rdata, 0);
        rst = 1'b0;
        oe_bad = 0;
        for (int i = 8; i < 13; i++) begin
            mosi = 1'b0;
            wait_clk(HALF);
            if (miso_oe !== 1'b0) oe_bad++;
            sck = 1'b1;
            wait_clk(HALF);
            if (miso_oe !== 1'b0) oe_bad++;
            sck = 1'b0;
        end
        wait_clk(HALF);
        check("midrd_ignored_oe", oe_bad, 0);
        check("midrd_ignored_no_wr", wv_total - wv0, 0);
        ss_n = 1'b1;
        wait_clk(8);

        wv0 = wv_total;
        spi_xfer(2'b00, {1'b0, 4'h1, 8'h11}, 13, rd, oe_bad);
        check("post_rst_wr_valid", wv_total - wv0, 1);
        check("post_rst_wr_addr", wr_addr, 4'h1);
        check("post_rst_wr_data", wr_data, 8'h11);
        for (int a = 0; a < 16; a++) begin
            loc_addr = a[3:0];
            wait_clk(1);
            check($sformatf("post_rst_reg%0d", a), loc_rdata, (a == 1) ? 8'h11 : 8'h00);
        end

        // Over-clocked write: 15 pulses
        wv0 = wv_total; fe0 = fe_total;
        spi_xfer(2'b00, {1'b0, 4'h3, 8'h5A}, 15, rd, oe_bad);
        check("ovr_wr_valid_cnt", wv_total - wv0, 1);
        check("ovr_wr_addr", wr_addr, 4'h3);
        check("ovr_wr_data", wr_data, 8'h5A);
        check("ovr_frame_err", fe_total - fe0, 2 * FE);
        loc_addr = 4'h3;
        wait_clk(1);
        check("ovr_loc_rdata", loc_rdata, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
